// File: rtl/fpu_op_issuer.sv
// fpu_op_issuer: runs one {op, a, b} command through the FPU strobe/ack
// handshakes and returns the result, or a NaN with a timeout flag.
module fpu_op_issuer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int TIMEOUT       = 1024,
   parameter int TW            = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout,
   output logic        busy,
   output logic [1:0]  fpu_op_sel,
   output logic [31:0] fpu_input_a,
   output logic        fpu_input_a_stb,
   input  logic        fpu_input_a_ack,
   output logic [31:0] fpu_input_b,
   output logic        fpu_input_b_stb,
   input  logic        fpu_input_b_ack,
   input  logic [31:0] fpu_output_z,
   input  logic        fpu_output_z_stb,
   output logic        fpu_output_z_ack
);

   typedef enum logic [2:0] {
      IDLE, SETUP, SEND_A, SEND_B, WAIT_Z, RESP
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [1:0]    op_q, op_d;
   logic [31:0]   a_q, a_d, b_q, b_d;

   logic        cmd_ready_q, cmd_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_tmo_q, rsp_tmo_d;
   logic        busy_q, busy_d;
   logic [1:0]  sel_q, sel_d;
   logic [31:0] in_a_q, in_a_d, in_b_q, in_b_d;
   logic        a_stb_q, a_stb_d, b_stb_q, b_stb_d;
   logic        z_ack_q, z_ack_d;

   logic accept, a_xfer, b_xfer, settle_done, tmo, rsp_hs;

   assign accept      = cmd_valid & cmd_ready_q;
   assign a_xfer      = a_stb_q & fpu_input_a_ack;
   assign b_xfer      = b_stb_q & fpu_input_b_ack;
   assign settle_done = (cnt_q == TW'(SETTLE_CYCLES - 1));
   assign tmo         = (cnt_q == TW'(TIMEOUT - 1));
   assign rsp_hs      = rsp_valid_q & rsp_ready;

   // State, counter, latched command and every registered output
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= 2'b00;
         a_q         <= '0;
         b_q         <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_tmo_q   <= 1'b0;
         busy_q      <= 1'b0;
         sel_q       <= 2'b00;
         in_a_q      <= '0;
         in_b_q      <= '0;
         a_stb_q     <= 1'b0;
         b_stb_q     <= 1'b0;
         z_ack_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tmo_q   <= rsp_tmo_d;
         busy_q      <= busy_d;
         sel_q       <= sel_d;
         in_a_q      <= in_a_d;
         in_b_q      <= in_b_d;
         a_stb_q     <= a_stb_d;
         b_stb_q     <= b_stb_d;
         z_ack_q     <= z_ack_d;
      end
   end

   // Next state; the counter times SETUP and each handshake state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = cmd_op;
               a_d     = cmd_a;
               b_d     = cmd_b;
               cnt_d   = '0;
               state_d = (cmd_op == 2'b00) ? RESP : SETUP;
            end
         end
         SETUP: begin
            if (settle_done) begin
               state_d = SEND_A;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SEND_A: begin
            if (a_xfer) begin
               state_d = SEND_B;
               cnt_d   = '0;
            end else if (tmo) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SEND_B: begin
            if (b_xfer) begin
               state_d = WAIT_Z;
               cnt_d   = '0;
            end else if (tmo) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_Z: begin
            if (fpu_output_z_stb || tmo) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; a timeout parks the FPU at once
   always_comb begin
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_tmo_d   = rsp_tmo_q;
      busy_d      = busy_q;
      sel_d       = sel_q;
      in_a_d      = in_a_q;
      in_b_d      = in_b_q;
      a_stb_d     = a_stb_q;
      b_stb_d     = b_stb_q;
      z_ack_d     = z_ack_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               if (cmd_op == 2'b00) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  rsp_tmo_d   = 1'b0;
               end else begin
                  sel_d = cmd_op;
               end
            end
         end
         SETUP: begin
            if (settle_done) begin
               a_stb_d = 1'b1;
               in_a_d  = a_q;
            end
         end
         SEND_A, SEND_B, WAIT_Z: begin
            if (state_q == SEND_A && a_xfer) begin
               a_stb_d = 1'b0;
               b_stb_d = 1'b1;
               in_b_d  = b_q;
            end else if (state_q == SEND_B && b_xfer) begin
               b_stb_d = 1'b0;
            end else if (state_q == WAIT_Z && fpu_output_z_stb) begin
               rsp_data_d  = fpu_output_z;
               rsp_tmo_d   = 1'b0;
               rsp_valid_d = 1'b1;
               z_ack_d     = 1'b1;
            end else if (tmo) begin
               a_stb_d     = 1'b0;
               b_stb_d     = 1'b0;
               rsp_data_d  = 32'h7FC0_0000;
               rsp_tmo_d   = 1'b1;
               rsp_valid_d = 1'b1;
               sel_d       = 2'b00;
            end
         end
         RESP: begin
            z_ack_d = 1'b0;
            sel_d   = 2'b00;
            if (rsp_hs) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign cmd_ready        = cmd_ready_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_data         = rsp_data_q;
   assign rsp_timeout      = rsp_tmo_q;
   assign busy             = busy_q;
   assign fpu_op_sel       = sel_q;
   assign fpu_input_a      = in_a_q;
   assign fpu_input_a_stb  = a_stb_q;
   assign fpu_input_b      = in_b_q;
   assign fpu_input_b_stb  = b_stb_q;
   assign fpu_output_z_ack = z_ack_q;

endmodule

// File: tb/tb_fpu_op_issuer.sv
// tb_fpu_op_issuer: drives commands into fpu_op_issuer against a
// behavioural FPU stand-in and checks every response against the rules.
module tb_fpu_op_issuer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_timeout;
   logic        busy;
   logic [1:0]  fpu_op_sel;
   logic [31:0] fpu_input_a;
   logic        fpu_input_a_stb;
   logic        fpu_input_a_ack;
   logic [31:0] fpu_input_b;
   logic        fpu_input_b_stb;
   logic        fpu_input_b_ack;
   logic [31:0] fpu_output_z;
   logic        fpu_output_z_stb;
   logic        fpu_output_z_ack;

   always #5 clk = ~clk;

   fpu_op_issuer #(
      .SETTLE_CYCLES(2),
      .TIMEOUT(16),
      .TW(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_a(cmd_a),
      .cmd_b(cmd_b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .rsp_timeout(rsp_timeout),
      .busy(busy),
      .fpu_op_sel(fpu_op_sel),
      .fpu_input_a(fpu_input_a),
      .fpu_input_a_stb(fpu_input_a_stb),
      .fpu_input_a_ack(fpu_input_a_ack),
      .fpu_input_b(fpu_input_b),
      .fpu_input_b_stb(fpu_input_b_stb),
      .fpu_input_b_ack(fpu_input_b_ack),
      .fpu_output_z(fpu_output_z),
      .fpu_output_z_stb(fpu_output_z_stb),
      .fpu_output_z_ack(fpu_output_z_ack)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Stand-in FPU result: any fixed function of op/a/b shows the
   // operands went through in order and the result came back untouched.
   function automatic logic [31:0] fpu_fn(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         2'b01:   return a + b;
         2'b10:   return a * b;
         default: return a ^ {b[15:0], b[31:16]};
      endcase
   endfunction

   // Behavioural FPU: random ack/result latency, dropped by op_sel=00
   bit          stall_b = 1'b0;
   bit          hold_z  = 1'b0;
   logic [31:0] la;
   logic        have_b;
   int          aw, bw, zd;

   always @(posedge clk) begin
      if (!rst || fpu_op_sel == 2'b00) begin
         fpu_input_a_ack  <= 1'b0;
         fpu_input_b_ack  <= 1'b0;
         fpu_output_z_stb <= 1'b0;
         fpu_output_z     <= '0;
         have_b           <= 1'b0;
         aw               <= 0;
         bw               <= 0;
         zd               <= 0;
      end else begin
         fpu_input_a_ack <= 1'b0;
         fpu_input_b_ack <= 1'b0;
         if (fpu_input_a_stb && !fpu_input_a_ack) begin
            if (aw >= 4 || $urandom_range(0, 2) == 0)
               fpu_input_a_ack <= 1'b1;
            aw <= aw + 1;
         end
         if (fpu_input_a_stb && fpu_input_a_ack) begin
            la <= fpu_input_a;
            aw <= 0;
         end
         if (fpu_input_b_stb && !fpu_input_b_ack && !stall_b) begin
            if (bw >= 4 || $urandom_range(0, 2) == 0)
               fpu_input_b_ack <= 1'b1;
            bw <= bw + 1;
         end
         if (fpu_input_b_stb && fpu_input_b_ack) begin
            fpu_output_z <= fpu_fn(fpu_op_sel, la, fpu_input_b);
            have_b       <= 1'b1;
            zd           <= $urandom_range(0, 6);
            bw           <= 0;
         end
         if (have_b && !fpu_output_z_stb && !hold_z) begin
            if (zd == 0) begin
               fpu_output_z_stb <= 1'b1;
               have_b           <= 1'b0;
            end else begin
               zd <= zd - 1;
            end
         end
         if (fpu_output_z_stb && fpu_output_z_ack)
            fpu_output_z_stb <= 1'b0;
      end
   end

   // Per-command activity counters, cleared by the driver after accept
   int         n_astb, n_bstb, n_zack, n_settle, n_selbad;
   bit         seen_a;
   logic [1:0] cur_op;

   always @(negedge clk) begin
      if (fpu_input_a_stb) begin
         n_astb++;
         seen_a = 1'b1;
      end
      if (fpu_input_b_stb) n_bstb++;
      if (fpu_output_z_ack) n_zack++;
      if (!seen_a && fpu_op_sel != 2'b00 && !fpu_input_a_stb) n_settle++;
      if ((fpu_input_a_stb || fpu_input_b_stb) && fpu_op_sel != cur_op)
         n_selbad++;
   end

   task automatic clr_mon(input logic [1:0] op);
      n_astb   = 0;
      n_bstb   = 0;
      n_zack   = 0;
      n_settle = 0;
      n_selbad = 0;
      seen_a   = 1'b0;
      cur_op   = op;
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int bp,
                         input bit stall);
      logic [31:0] exp_d;
      logic        exp_t;
      bit          norm;
      int          n;
      norm = (op != 2'b00) && !stall;
      if (op == 2'b00) begin
         exp_d = '0;
         exp_t = 1'b0;
      end else if (stall) begin
         exp_d = 32'h7FC0_0000;
         exp_t = 1'b1;
      end else begin
         exp_d = fpu_fn(op, a, b);
         exp_t = 1'b0;
      end
      stall_b = stall;
      @(negedge clk);
      chk("idle_ready", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = $urandom_range(0, 3);
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      clr_mon(op);
      @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 200) begin
         chk("busy_wait", 64'({busy, cmd_ready}), 64'(2'b10));
         @(negedge clk);
         n++;
      end
      chk("rsp_arrive", 64'(rsp_valid), 64'(1));
      if (op == 2'b00) chk("noop_lat", 64'(n), 64'(0));
      else chk("settle", 64'(n_settle), 64'(2));
      if (stall) chk("tmo_cycles", 64'(n_bstb), 64'(16));
      chk("rsp_data", 64'(rsp_data), 64'(exp_d));
      chk("rsp_tmo", 64'(rsp_timeout), 64'(exp_t));
      chk("first_sel", 64'(fpu_op_sel), norm ? 64'(op) : 64'(0));
      chk("first_zack", 64'(fpu_output_z_ack), 64'(norm));
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk("bp_hold", 64'({rsp_valid, cmd_ready, rsp_timeout, rsp_data}),
             64'({1'b1, 1'b0, exp_t, exp_d}));
         chk("bp_sel", 64'(fpu_op_sel), 64'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("post_idle", 64'({rsp_valid, cmd_ready, busy, fpu_op_sel}),
          64'({1'b0, 1'b1, 1'b0, 2'b00}));
      chk("zack_count", 64'(n_zack), 64'(norm));
      if (op == 2'b00) chk("noop_stb", 64'(n_astb + n_bstb), 64'(0));
      chk("sel_during", 64'(n_selbad), 64'(0));
      stall_b = 1'b0;
   endtask

   task automatic reset_mid();
      int n;
      hold_z = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_a     = 32'h4040_0000;
      cmd_b     = 32'h4000_0000;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      clr_mon(2'b10);
      @(negedge clk);
      n = 0;
      while (!(n_bstb > 0 && !fpu_input_b_stb) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("reach_waitz", 64'(n < 40), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid", 64'({rsp_valid, cmd_ready, busy, fpu_op_sel}),
          64'({1'b0, 1'b1, 1'b0, 2'b00}));
      hold_z = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0] op;
      bit         st;
      clr_mon(2'b00);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ctl", 64'({cmd_ready, rsp_valid, busy, rsp_timeout}),
          64'(4'b1000));
      chk("rst_fpu", 64'({fpu_op_sel, fpu_input_a_stb, fpu_input_b_stb,
                           fpu_output_z_ack}), 64'(0));
      chk("rst_data", 64'({rsp_data, fpu_input_a | fpu_input_b}), 64'(0));
      rst = 1'b1;

      do_cmd(2'b01, 32'h3FC0_0000, 32'h4010_0000, 0, 1'b0);
      do_cmd(2'b10, 32'h4040_0000, 32'h4000_0000, 0, 1'b0);
      do_cmd(2'b11, 32'h40C0_0000, 32'h4000_0000, 0, 1'b0);
      do_cmd(2'b01, 32'h3F80_0000, 32'h3F80_0000, 10, 1'b0);
      do_cmd(2'b11, 32'h4120_0000, 32'h4000_0000, 3, 1'b1);
      do_cmd(2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0);
      reset_mid();
      do_cmd(2'b01, 32'h3FC0_0000, 32'h4010_0000, 0, 1'b0);

      for (int k = 0; k < 24; k++) begin
         op = 2'($urandom_range(0, 3));
         st = (op != 2'b00) && ($urandom_range(0, 5) == 0);
         do_cmd(op, $urandom, $urandom, $urandom_range(0, 3), st);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
